// File: rtl/mem_stage_pkg.sv
// Shared constants and FSM encoding for the memory-access stage.
package mem_stage_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_REGADDR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_stage_mem2wb.sv
// MEM/WB pipeline register: loads the selected stage result, or zeros when a bubble is requested.
// Latency 1 cycle; no backpressure, a new value (or bubble) is captured on every edge.
module mem2wb
  import mem_stage_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int REGADDR_W = DEF_REGADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bubble,
  input  logic                 regwrite_in,
  input  logic                 memtoreg_in,
  input  logic [WIDTH-1:0]     readdata_in,
  input  logic [WIDTH-1:0]     aluout_in,
  input  logic [REGADDR_W-1:0] regaddr_in,
  input  logic                 exc_in,
  output logic                 regwrite_wb,
  output logic                 memtoreg_wb,
  output logic [WIDTH-1:0]     readdata_wb,
  output logic [WIDTH-1:0]     aluout_wb,
  output logic [REGADDR_W-1:0] regaddr_wb,
  output logic                 exc_wb
);

  logic                 regwrite_d, regwrite_q;
  logic                 memtoreg_d, memtoreg_q;
  logic [WIDTH-1:0]     readdata_d, readdata_q;
  logic [WIDTH-1:0]     aluout_d, aluout_q;
  logic [REGADDR_W-1:0] regaddr_d, regaddr_q;
  logic                 exc_d, exc_q;

  always_comb begin
    regwrite_d = regwrite_in;
    memtoreg_d = memtoreg_in;
    readdata_d = readdata_in;
    aluout_d   = aluout_in;
    regaddr_d  = regaddr_in;
    exc_d      = exc_in;
    if (bubble) begin
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      readdata_d = '0;
      aluout_d   = '0;
      regaddr_d  = '0;
      exc_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      readdata_q <= '0;
      aluout_q   <= '0;
      regaddr_q  <= '0;
      exc_q      <= 1'b0;
    end else begin
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      readdata_q <= readdata_d;
      aluout_q   <= aluout_d;
      regaddr_q  <= regaddr_d;
      exc_q      <= exc_d;
    end
  end

  assign regwrite_wb = regwrite_q;
  assign memtoreg_wb = memtoreg_q;
  assign readdata_wb = readdata_q;
  assign aluout_wb   = aluout_q;
  assign regaddr_wb  = regaddr_q;
  assign exc_wb      = exc_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues loads/stores on a ready/valid dmem port and owns MEM/WB; ALU ops take 1 cycle, memory ops 1 issue + N wait cycles.
// Stalls upstream while an access is outstanding; MEM_MISALIGN_CHECK_EN flags misaligned accesses instead of issuing them.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int REGADDR_W = DEF_REGADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 regwrite_mem,
  input  logic                 memtoreg_mem,
  input  logic                 memwrite_mem,
  input  logic [WIDTH-1:0]     aluout_mem,
  input  logic [WIDTH-1:0]     writedata_mem,
  input  logic [REGADDR_W-1:0] regaddr_mem,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [WIDTH-1:0]     dmem_addr,
  output logic [WIDTH-1:0]     dmem_wdata,
  input  logic                 dmem_ready,
  input  logic [WIDTH-1:0]     dmem_rdata,
  output logic                 stall_mem,
  output logic                 regwrite_wb,
  output logic                 memtoreg_wb,
  output logic [WIDTH-1:0]     readdata_wb,
  output logic [WIDTH-1:0]     aluout_wb,
  output logic [REGADDR_W-1:0] regaddr_wb,
  output logic                 exc_misalign_wb
);

  state_t               state_d, state_q;
  logic                 req_we_d, req_we_q;
  logic [WIDTH-1:0]     req_addr_d, req_addr_q;
  logic [WIDTH-1:0]     req_wdata_d, req_wdata_q;
  logic                 req_regwrite_d, req_regwrite_q;
  logic                 req_memtoreg_d, req_memtoreg_q;
  logic [REGADDR_W-1:0] req_regaddr_d, req_regaddr_q;

  logic                 memop;
  logic                 misalign;
  logic                 issue;

  logic                 wb_bubble;
  logic                 wb_regwrite;
  logic                 wb_memtoreg;
  logic [WIDTH-1:0]     wb_readdata;
  logic [WIDTH-1:0]     wb_aluout;
  logic [REGADDR_W-1:0] wb_regaddr;
  logic                 wb_exc;

  assign memop = memtoreg_mem | memwrite_mem;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = memop & (aluout_mem[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign issue = (state_q == IDLE) & memop & ~misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      req_we_q       <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
      req_regwrite_q <= 1'b0;
      req_memtoreg_q <= 1'b0;
      req_regaddr_q  <= '0;
    end else begin
      state_q        <= state_d;
      req_we_q       <= req_we_d;
      req_addr_q     <= req_addr_d;
      req_wdata_q    <= req_wdata_d;
      req_regwrite_q <= req_regwrite_d;
      req_memtoreg_q <= req_memtoreg_d;
      req_regaddr_q  <= req_regaddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = BUSY;
      BUSY:    if (dmem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request is captured once at issue so the memory port never follows upstream changes.
  always_comb begin
    req_we_d       = req_we_q;
    req_addr_d     = req_addr_q;
    req_wdata_d    = req_wdata_q;
    req_regwrite_d = req_regwrite_q;
    req_memtoreg_d = req_memtoreg_q;
    req_regaddr_d  = req_regaddr_q;
    if (issue) begin
      req_we_d       = memwrite_mem;
      req_addr_d     = aluout_mem;
      req_wdata_d    = writedata_mem;
      req_regwrite_d = regwrite_mem;
      req_memtoreg_d = memtoreg_mem;
      req_regaddr_d  = regaddr_mem;
    end
  end

  always_comb begin
    dmem_req    = (state_q == BUSY);
    dmem_we     = req_we_q;
    dmem_addr   = req_addr_q;
    dmem_wdata  = req_wdata_q;
    stall_mem   = 1'b0;
    wb_bubble   = 1'b0;
    wb_regwrite = regwrite_mem;
    wb_memtoreg = 1'b0;
    wb_readdata = '0;
    wb_aluout   = aluout_mem;
    wb_regaddr  = regaddr_mem;
    wb_exc      = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          stall_mem = 1'b1;
          wb_bubble = 1'b1;
        end else if (misalign) begin
          wb_regwrite = 1'b0;
          wb_exc      = 1'b1;
        end
      end
      BUSY: begin
        stall_mem = ~dmem_ready;
        if (dmem_ready) begin
          wb_regwrite = req_regwrite_q;
          wb_memtoreg = req_memtoreg_q;
          wb_readdata = req_we_q ? '0 : dmem_rdata;
          wb_aluout   = req_addr_q;
          wb_regaddr  = req_regaddr_q;
        end else begin
          wb_bubble = 1'b1;
        end
      end
      default: wb_bubble = 1'b1;
    endcase
  end

  mem2wb #(
    .WIDTH     (WIDTH),
    .REGADDR_W (REGADDR_W)
  ) u_mem2wb (
    .clk         (clk),
    .rst         (rst),
    .bubble      (wb_bubble),
    .regwrite_in (wb_regwrite),
    .memtoreg_in (wb_memtoreg),
    .readdata_in (wb_readdata),
    .aluout_in   (wb_aluout),
    .regaddr_in  (wb_regaddr),
    .exc_in      (wb_exc),
    .regwrite_wb (regwrite_wb),
    .memtoreg_wb (memtoreg_wb),
    .readdata_wb (readdata_wb),
    .aluout_wb   (aluout_wb),
    .regaddr_wb  (regaddr_wb),
    .exc_wb      (exc_misalign_wb)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected MEM/WB contents are queued as stimulus is driven and checked after each edge.
module tb_mem_stage;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic [31:0] readdata;
    logic [31:0] aluout;
    logic [4:0]  regaddr;
    logic        exc;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwrite_mem, memtoreg_mem, memwrite_mem;
  logic [31:0] aluout_mem, writedata_mem;
  logic [4:0]  regaddr_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall_mem;
  logic        regwrite_wb, memtoreg_wb;
  logic [31:0] readdata_wb, aluout_wb;
  logic [4:0]  regaddr_wb;
  logic        exc_misalign_wb;

  int checks = 0;
  int errors = 0;
  wb_t exp_q[$];

  localparam wb_t BUBBLE = '0;

  always #5 clk = ~clk;

  mem_stage #(.WIDTH(32), .REGADDR_W(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .regwrite_mem    (regwrite_mem),
    .memtoreg_mem    (memtoreg_mem),
    .memwrite_mem    (memwrite_mem),
    .aluout_mem      (aluout_mem),
    .writedata_mem   (writedata_mem),
    .regaddr_mem     (regaddr_mem),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_ready      (dmem_ready),
    .dmem_rdata      (dmem_rdata),
    .stall_mem       (stall_mem),
    .regwrite_wb     (regwrite_wb),
    .memtoreg_wb     (memtoreg_wb),
    .readdata_wb     (readdata_wb),
    .aluout_wb       (aluout_wb),
    .regaddr_wb      (regaddr_wb),
    .exc_misalign_wb (exc_misalign_wb)
  );

  function automatic wb_t mk_wb(logic rw, logic mtr, logic [31:0] rd, logic [31:0] alu,
                                logic [4:0] ra, logic exc);
    wb_t w;
    w.regwrite = rw;
    w.memtoreg = mtr;
    w.readdata = rd;
    w.aluout   = alu;
    w.regaddr  = ra;
    w.exc      = exc;
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic mtr, input logic mw, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] ra, input logic rdy,
                       input logic [31:0] rdata);
    regwrite_mem  = rw;
    memtoreg_mem  = mtr;
    memwrite_mem  = mw;
    aluout_mem    = alu;
    writedata_mem = wd;
    regaddr_mem   = ra;
    dmem_ready    = rdy;
    dmem_rdata    = rdata;
  endtask

  // Combinational outputs, sampled mid-cycle after inputs have settled.
  task automatic comb_chk(input string tag, input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic stall);
    #1;
    check({tag, ".req"}, {31'b0, dmem_req}, {31'b0, req});
    check({tag, ".stall"}, {31'b0, stall_mem}, {31'b0, stall});
    if (req) begin
      check({tag, ".we"}, {31'b0, dmem_we}, {31'b0, we});
      check({tag, ".addr"}, dmem_addr, addr);
      if (we) check({tag, ".wdata"}, dmem_wdata, wdata);
    end
  endtask

  task automatic tick(input string tag, input wb_t exp);
    wb_t e;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".regwrite_wb"}, {31'b0, regwrite_wb}, {31'b0, e.regwrite});
    check({tag, ".memtoreg_wb"}, {31'b0, memtoreg_wb}, {31'b0, e.memtoreg});
    check({tag, ".readdata_wb"}, readdata_wb, e.readdata);
    check({tag, ".aluout_wb"}, aluout_wb, e.aluout);
    check({tag, ".regaddr_wb"}, {27'b0, regaddr_wb}, {27'b0, e.regaddr});
    check({tag, ".exc_wb"}, {31'b0, exc_misalign_wb}, {31'b0, e.exc});
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
  endtask

  initial begin
    // Reset with a pending load and a ready memory: nothing may be issued.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd3, 1'b1, 32'h1111_1111);
    #1;
    tick("rst0", BUBBLE);
    tick("rst1", BUBBLE);
    check("rst.req", {31'b0, dmem_req}, 32'd0);
    rst = 1'b0;
    nop();
    comb_chk("rst_idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick("rst_idle", BUBBLE);

    // ALU ops pass straight through in one cycle.
    drive(1'b1, 1'b0, 1'b0, 32'h0000_00AA, 32'hFFFF_FFFF, 5'd7, 1'b0, 32'h0);
    comb_chk("alu1", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick("alu1", mk_wb(1'b1, 1'b0, 32'h0, 32'h0000_00AA, 5'd7, 1'b0));
    drive(1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 5'd31, 1'b1, 32'hAAAA_AAAA);
    comb_chk("alu2", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick("alu2", mk_wb(1'b0, 1'b0, 32'h0, 32'h1234_5678, 5'd31, 1'b0));

    // Load 0x100 with three wait cycles; upstream inputs are scrambled while busy.
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd3, 1'b0, 32'h0);
    comb_chk("ld_issue", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick("ld_issue", BUBBLE);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0 + i, 32'h5A5A_0000 + i, 5'd30, 1'b0, 32'h0BAD_0000);
      comb_chk($sformatf("ld_wait%0d", i), 1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b1);
      tick($sformatf("ld_wait%0d", i), BUBBLE);
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd3, 1'b1, 32'hDEAD_BEEF);
    comb_chk("ld_done", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    tick("ld_done", mk_wb(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0100, 5'd3, 1'b0));

    // Store 0x200 then load 0x204, zero-wait memory: two distinct requests.
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_1234, 5'd0, 1'b1, 32'h5555_5555);
    comb_chk("st_issue", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick("st_issue", BUBBLE);
    comb_chk("st_done", 1'b1, 1'b1, 32'h0000_0200, 32'h0000_1234, 1'b0);
    tick("st_done", mk_wb(1'b0, 1'b0, 32'h0, 32'h0000_0200, 5'd0, 1'b0));
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0204, 32'h0, 5'd9, 1'b1, 32'hCAFE_F00D);
    comb_chk("ld2_issue", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick("ld2_issue", BUBBLE);
    comb_chk("ld2_done", 1'b1, 1'b0, 32'h0000_0204, 32'h0, 1'b0);
    tick("ld2_done", mk_wb(1'b1, 1'b1, 32'hCAFE_F00D, 32'h0000_0204, 5'd9, 1'b0));

    // Reset in the second busy cycle; a late ready must be ignored.
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd4, 1'b0, 32'h0);
    comb_chk("rb_issue", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick("rb_issue", BUBBLE);
    comb_chk("rb_busy1", 1'b1, 1'b0, 32'h0000_0300, 32'h0, 1'b1);
    tick("rb_busy1", BUBBLE);
    rst = 1'b1;
    comb_chk("rb_busy2", 1'b1, 1'b0, 32'h0000_0300, 32'h0, 1'b1);
    tick("rb_rst", BUBBLE);
    rst = 1'b0;
    nop();
    dmem_ready = 1'b1;
    dmem_rdata = 32'h0BAD_0BAD;
    comb_chk("rb_late", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick("rb_late", BUBBLE);

`ifdef MEM_MISALIGN_CHECK_EN
    // Misaligned load is flagged, not issued.
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd5, 1'b0, 32'h0);
    comb_chk("mis", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick("mis", mk_wb(1'b0, 1'b0, 32'h0, 32'h0000_0102, 5'd5, 1'b1));
    nop();
    comb_chk("mis_after", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick("mis_after", BUBBLE);
`else
    // Without the check a misaligned address goes to memory unchanged.
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd5, 1'b0, 32'h0);
    comb_chk("mis_issue", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick("mis_issue", BUBBLE);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h0102_0304;
    comb_chk("mis_done", 1'b1, 1'b0, 32'h0000_0102, 32'h0, 1'b0);
    tick("mis_done", mk_wb(1'b1, 1'b1, 32'h0102_0304, 32'h0000_0102, 5'd5, 1'b0));
`endif

    nop();
    comb_chk("end_idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick("end_idle", BUBBLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage sitting between the EXE/MEM pipeline register and the WB stage.
- Consumes the EXE/MEM register outputs: control bits, ALU result, store data and destination register.
- Performs loads and stores over a variable-latency ready/valid data-memory port and stalls upstream while an access is outstanding.
- Owns the MEM/WB pipeline register, so WB sees registered results only.

Parameters:
- WIDTH, 32, datapath and address width (matches the `WIDTH define).
- REGADDR_W, 5, register-file address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- regwrite_mem  in  1  instruction in MEM writes the register file.
- memtoreg_mem  in  1  instruction is a load.
- memwrite_mem  in  1  instruction is a store.
- aluout_mem  in  WIDTH  ALU result (memory address for loads/stores).
- writedata_mem  in  WIDTH  store data.
- regaddr_mem  in  REGADDR_W  destination register.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  WIDTH  request address.
- dmem_wdata  out  WIDTH  store data.
- dmem_ready  in  1  memory completes the request this cycle.
- dmem_rdata  in  WIDTH  load data, valid with dmem_ready.
- stall_mem  out  1  hold PC, IF/ID, ID/EXE and EXE/MEM registers this cycle.
- regwrite_wb  out  1  registered write enable to WB.
- memtoreg_wb  out  1  registered WB mux select.
- readdata_wb  out  WIDTH  registered load data.
- aluout_wb  out  WIDTH  registered ALU result.
- regaddr_wb  out  REGADDR_W  registered destination register.
- exc_misalign_wb  out  1  registered misaligned-access flag (see Optional Feature).

Behaviour:
- Definition: memop = memtoreg_mem | memwrite_mem.
- FSM states: IDLE, BUSY.
- Reset (rst=1 at edge):
  - state <= IDLE.
  - All *_wb outputs <= 0.
  - Latched request registers <= 0.
  - Combinational outputs therefore settle to dmem_req=0 and stall_mem=0 in the following cycle.
- IDLE, memop=0:
  - No request.
  - stall_mem=0.
  - MEM/WB loads pass-through: regwrite_wb<=regwrite_mem, memtoreg_wb<=0, aluout_wb<=aluout_mem, regaddr_wb<=regaddr_mem, readdata_wb<=0.
- IDLE, memop=1:
  - Latch addr, wdata, we=memwrite_mem, regwrite, memtoreg and regaddr into internal request registers.
  - state <= BUSY.
  - stall_mem=1 (combinational).
  - MEM/WB loads a bubble: all *_wb <= 0.
- BUSY:
  - dmem_req=1.
  - dmem_we, dmem_addr and dmem_wdata are driven only from the latched registers, so they are stable regardless of upstream.
  - stall_mem = ~dmem_ready.
- BUSY with dmem_ready=1:
  - Load into MEM/WB: readdata_wb<=dmem_rdata (loads; 0 for stores), plus the latched regwrite, memtoreg, aluout and regaddr.
  - state <= IDLE.
  - stall_mem drops in this same cycle, so EXE/MEM advances on this edge.
- BUSY with dmem_ready=0: hold state and request; MEM/WB loads a bubble each cycle.
- dmem_req=0 outside BUSY; dmem_ready in IDLE is ignored.
- Latency:
  - Non-memory instruction: 1 cycle MEM→WB, no stall.
  - Memory instruction: 1 issue cycle + N≥1 wait cycles; stall_mem is high for N cycles, where N counts up to and including the first dmem_ready cycle minus one.
  - Minimum one stall cycle per access, with one bubble into WB per stall cycle.
- Back-to-back loads/stores: each re-enters IDLE and issues again; there is no request pipelining.
- Stores: regwrite_wb follows the latched regwrite (0 from decode for stores).
- Reset mid-BUSY: request abandoned; dmem_req low from the next cycle; a late dmem_ready is ignored. The memory side must tolerate an abandoned request.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined:
  - In IDLE with memop=1 and aluout_mem[1:0]!=0, no request is issued and stall_mem=0.
  - MEM/WB loads regwrite_wb=0, memtoreg_wb=0, regaddr_wb=regaddr_mem, aluout_wb=aluout_mem, exc_misalign_wb<=1 for one cycle.
- Undefined:
  - The address is passed unchecked (low bits go to the memory).
  - exc_misalign_wb is held at 0 constantly.
  - The port exists in both builds.

Decomposition:
- Shared package/defines: WIDTH, REGADDR_W, FSM state encodings (IDLE=1'b0, BUSY=1'b1).
- Sub-module: mem2wb, holding only the MEM/WB register with a load-value-or-bubble select. It keeps the pipeline-register style consistent with the other stage registers.
- The FSM and request latch stay in mem_stage.

Test Plan:
- Reset: assert rst with dmem_ready=1 and memop=1 → next cycle all *_wb=0, dmem_req=0, stall_mem=0.
- ALU op (regwrite=1, aluout=0x0000_00AA, regaddr=7) → next cycle regwrite_wb=1, aluout_wb=0xAA, regaddr_wb=7, stall_mem=0 throughout.
- Load addr 0x100, memory returns 0xDEADBEEF after 3 wait cycles → dmem_req high for 4 cycles with addr=0x100 and we=0. stall_mem high for 4 cycles, dropping in the ready cycle. Next cycle readdata_wb=0xDEADBEEF and memtoreg_wb=1; the intervening *_wb values are bubbles.
- Store addr 0x200, data 0x1234 followed by a load to 0x204, both with zero-wait memory → two separate requests, the second with dmem_we=0 and addr=0x204. One stall cycle each; no dropped or duplicated access.
- rst asserted in the second BUSY cycle of a load, dmem_ready pulsed one cycle after reset → state IDLE, no WB write, dmem_req=0.
- With MEM_MISALIGN_CHECK_EN: load to 0x102 → no dmem_req, stall_mem=0, exc_misalign_wb=1 for exactly one cycle, regwrite_wb=0.
